game_ctrl_fsm: RTL and testbench

//  Top-level sequencer for the 2048 board datapath. It turns debounced direction buttons into

---
 rtl/game_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm.sv
// Top-level sequencer for the 2048 board datapath: turns button presses into move commands,
// waits for each move to finish, resolves win/lose and tracks move count and move timeouts.
module game_ctrl_fsm #(
    parameter int unsigned MoveTimeout = 64,
    parameter int unsigned CountW      = 16,
    parameter int unsigned SyncStages  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [3:0]        btn_i,
    input  logic              start_i,
    input  logic              move_done_i,
    input  logic              board_changed_i,
    input  logic              won_i,
    input  logic              lost_i,
    output logic [2:0]        q_o,
    output logic [1:0]        direction_o,
    output logic              en_game_logic_o,
    output logic              en_new_tile_o,
    output logic [CountW-1:0] move_count_o,
    output logic              timeout_err_o
);

    localparam int unsigned TmrW = $clog2(MoveTimeout);

    typedef enum logic [2:0] {
        StClear = 3'b000,
        StSpawn = 3'b001,
        StIdle  = 3'b010,
        StMove  = 3'b011,
        StCheck = 3'b100,
        StWon   = 3'b101,
        StLost  = 3'b110
    } state_e;

    state_e                      state_q, state_d;
    logic [SyncStages-1:0][3:0]  sync_q;
    logic [3:0]                  btn_prev_q;
    logic [3:0]                  btn_rise;
    logic                        btn_evt;
    logic [1:0]                  btn_dir;
    logic [1:0]                  dir_q, dir_d;
    logic [TmrW-1:0]             tmr_q, tmr_d;
    logic [CountW-1:0]           cnt_q, cnt_d;
    logic                        terr_q, terr_d;
    logic                        changed_q, changed_d;
    logic                        tile_q, tile_d;
    logic                        tmr_expired;

    assign btn_rise    = sync_q[SyncStages-1] & ~btn_prev_q;
    assign btn_evt     = |btn_rise;
    assign tmr_expired = (tmr_q == TmrW'(MoveTimeout - 1));

    // Simultaneous presses resolve up > down > left > right
    always_comb begin
        btn_dir = 2'b00;
        if (btn_rise[3])      btn_dir = 2'b00;
        else if (btn_rise[2]) btn_dir = 2'b01;
        else if (btn_rise[1]) btn_dir = 2'b10;
        else if (btn_rise[0]) btn_dir = 2'b11;
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        changed_d = changed_q;
        tmr_d     = (state_q == StMove) ? tmr_q + TmrW'(1) : '0;

        case (state_q)
            StClear: state_d = StSpawn;
            StSpawn: state_d = StIdle;
            StIdle: begin
                if (btn_evt) begin
                    state_d = StMove;
                    dir_d   = btn_dir;
                end
            end
            StMove: begin
                if (move_done_i) begin
                    state_d   = StCheck;
                    changed_d = board_changed_i;
                    if (board_changed_i && (cnt_q != '1)) cnt_d = cnt_q + CountW'(1);
                end else if (tmr_expired) begin
                    state_d   = StCheck;
                    changed_d = 1'b0;
                    terr_d    = 1'b1;
                end
            end
            StCheck: begin
                if (won_i)          state_d = StWon;
                else if (lost_i)    state_d = StLost;
                else if (changed_q) state_d = StSpawn;
                else                state_d = StIdle;
            end
            StWon, StLost: state_d = state_q;
            default: state_d = StClear;
        endcase

        if (start_i) begin
            state_d = StClear;
            cnt_d   = '0;
            terr_d  = 1'b0;
        end

        tile_d = (state_d == StSpawn);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StClear;
            sync_q     <= '0;
            btn_prev_q <= '0;
            dir_q      <= 2'b00;
            tmr_q      <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
            changed_q  <= 1'b0;
            tile_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SyncStages-2:0], btn_i};
            btn_prev_q <= sync_q[SyncStages-1];
            dir_q      <= dir_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
            changed_q  <= changed_d;
            tile_q     <= tile_d;
        end
    end

    assign q_o             = state_q;
    assign direction_o     = dir_q;
    assign en_game_logic_o = (state_q == StMove);
    assign en_new_tile_o   = tile_q;
    assign move_count_o    = cnt_q;
    assign timeout_err_o   = terr_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm; expected outputs are queued as stimulus is applied and
// compared once the DUT has clocked.
module tb_game_ctrl_fsm;

    localparam logic [2:0] CLR = 3'd0, SPN = 3'd1, IDL = 3'd2, MOV = 3'd3;
    localparam logic [2:0] CHK = 3'd4, WN = 3'd5, LST = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = 4'b0;
    logic        start = 1'b0, move_done = 1'b0, board_changed = 1'b0, won = 1'b0, lost = 1'b0;
    logic [2:0]  q;
    logic [1:0]  direction;
    logic        en_game_logic, en_new_tile, timeout_err;
    logic [15:0] move_count;

    game_ctrl_fsm #(
        .MoveTimeout(64),
        .CountW     (16),
        .SyncStages (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .btn_i          (btn),
        .start_i        (start),
        .move_done_i    (move_done),
        .board_changed_i(board_changed),
        .won_i          (won),
        .lost_i         (lost),
        .q_o            (q),
        .direction_o    (direction),
        .en_game_logic_o(en_game_logic),
        .en_new_tile_o  (en_new_tile),
        .move_count_o   (move_count),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  q;
        logic [1:0]  dir;
        logic [15:0] cnt;
        logic        terr;
        logic        tile;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [1:0]  m_dir = 2'b00;
    logic [15:0] m_cnt = 16'd0;
    logic        m_terr = 1'b0;

    task automatic cmp(input string tag, input string fld, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s.%s got %0h expected %0h", tag, fld, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] eq, input logic etile);
        exp_t e;
        e.tag  = tag;
        e.q    = eq;
        e.dir  = m_dir;
        e.cnt  = m_cnt;
        e.terr = m_terr;
        e.tile = etile;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        cmp(e.tag, "q", 16'(q), 16'(e.q));
        cmp(e.tag, "direction", 16'(direction), 16'(e.dir));
        cmp(e.tag, "move_count", move_count, e.cnt);
        cmp(e.tag, "timeout_err", 16'(timeout_err), 16'(e.terr));
        cmp(e.tag, "en_new_tile", 16'(en_new_tile), 16'(e.tile));
        cmp(e.tag, "en_game_logic", 16'(en_game_logic), 16'(e.q == MOV));
    endtask

    // One clock: queue the expectation, let the DUT clock, then compare on the falling edge
    task automatic step(input string tag, input logic [2:0] eq, input logic etile);
        expect_out(tag, eq, etile);
        @(negedge clk);
        compare_head();
    endtask

    task automatic check_now(input string tag, input logic [2:0] eq, input logic etile);
        expect_out(tag, eq, etile);
        compare_head();
    endtask

    // Release all buttons long enough to clear edge state, then press; lands on MOVE entry
    task automatic press(input string tag, input logic [3:0] b, input logic [1:0] d);
        btn = 4'b0;
        repeat (3) @(negedge clk);
        btn = b;
        step({tag, "_sync1"}, IDL, 1'b0);
        step({tag, "_sync2"}, IDL, 1'b0);
        m_dir = d;
        step({tag, "_move"}, MOV, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_now("rst_hold", CLR, 1'b0);
        rst_n = 1'b1;
        step("rst_spawn", SPN, 1'b1);
        step("rst_idle", IDL, 1'b0);
        step("idle_stay", IDL, 1'b0);

        move_done = 1'b1; board_changed = 1'b1;
        step("done_in_idle", IDL, 1'b0);
        move_done = 1'b0; board_changed = 1'b0;

        // Left, held for the whole move; finishes 5 cycles after MOVE entry
        press("left", 4'b0010, 2'b10);
        repeat (4) step("left_wait", MOV, 1'b0);
        move_done = 1'b1; board_changed = 1'b1; m_cnt++;
        step("left_check", CHK, 1'b0);
        move_done = 1'b0; board_changed = 1'b0;
        step("left_spawn", SPN, 1'b1);
        step("left_idle", IDL, 1'b0);
        repeat (2) step("left_held", IDL, 1'b0);

        // Right, board unchanged: no spawn, count holds
        press("right", 4'b0001, 2'b11);
        move_done = 1'b1; board_changed = 1'b0;
        step("noop_check", CHK, 1'b0);
        move_done = 1'b0;
        step("noop_idle", IDL, 1'b0);
        step("noop_idle2", IDL, 1'b0);

        // All four together -> up; a fresh edge during MOVE must be dropped
        press("all", 4'b1111, 2'b00);
        btn = 4'b0;
        repeat (3) step("all_release", MOV, 1'b0);
        btn = 4'b0100;
        repeat (4) step("all_late_edge", MOV, 1'b0);
        move_done = 1'b1; board_changed = 1'b1; m_cnt++;
        step("all_check", CHK, 1'b0);
        move_done = 1'b0; board_changed = 1'b0;
        step("all_spawn", SPN, 1'b1);
        step("all_idle", IDL, 1'b0);
        repeat (3) step("all_no_queue", IDL, 1'b0);

        // Down with no move_done: forced exit on the 64th edge after entry
        press("tmo", 4'b0100, 2'b01);
        repeat (62) @(negedge clk);
        step("tmo_last", MOV, 1'b0);
        m_terr = 1'b1;
        step("tmo_check", CHK, 1'b0);
        step("tmo_idle", IDL, 1'b0);
        step("tmo_sticky", IDL, 1'b0);

        // won and lost together: won wins
        press("win", 4'b0001, 2'b11);
        won = 1'b1; lost = 1'b1; move_done = 1'b1; board_changed = 1'b1; m_cnt++;
        step("win_check", CHK, 1'b0);
        move_done = 1'b0; board_changed = 1'b0;
        step("win_won", WN, 1'b0);
        repeat (2) step("win_hold", WN, 1'b0);
        start = 1'b1; m_cnt = 16'd0; m_terr = 1'b0;
        step("start_clear", CLR, 1'b0);
        step("start_held", CLR, 1'b0);
        start = 1'b0; won = 1'b0; lost = 1'b0;
        step("restart_spawn", SPN, 1'b1);
        step("restart_idle", IDL, 1'b0);

        // lost alone
        press("lose", 4'b1000, 2'b00);
        lost = 1'b1; move_done = 1'b1; board_changed = 1'b0;
        step("lose_check", CHK, 1'b0);
        move_done = 1'b0;
        step("lose_lost", LST, 1'b0);
        step("lose_hold", LST, 1'b0);
        start = 1'b1;
        step("lose_start", CLR, 1'b0);
        start = 1'b0; lost = 1'b0;
        step("lose_spawn", SPN, 1'b1);
        step("lose_idle", IDL, 1'b0);

        // Async reset in the middle of a MOVE with a nonzero count
        press("pre", 4'b0010, 2'b10);
        move_done = 1'b1; board_changed = 1'b1; m_cnt++;
        step("pre_check", CHK, 1'b0);
        move_done = 1'b0; board_changed = 1'b0;
        step("pre_spawn", SPN, 1'b1);
        step("pre_idle", IDL, 1'b0);
        press("rstmv", 4'b0001, 2'b11);
        step("rstmv_run", MOV, 1'b0);
        #2 rst_n = 1'b0;
        m_dir = 2'b00; m_cnt = 16'd0; m_terr = 1'b0;
        #1 check_now("rst_async", CLR, 1'b0);
        @(negedge clk);
        check_now("rst_low", CLR, 1'b0);
        btn = 4'b0;
        rst_n = 1'b1;
        step("rst2_spawn", SPN, 1'b1);
        step("rst2_idle", IDL, 1'b0);
        step("rst2_idle2", IDL, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
